// File: rtl/diretorio_msi_n.sv
// rtl/diretorio_msi_n.sv - MSI coherence directory for N processors with memory and message handshakes
module diretorio_msi_n #(
  parameter int N_PROC   = 2,
  parameter int N_BLOCKS = 8,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int PW       = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [PW-1:0]     req_proc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              msg_valid,
  output logic [2:0]        msg_type,
  output logic [N_PROC-1:0] msg_dest,
  output logic [ADDR_W-1:0] msg_addr,
  input  logic              msg_ack,
  input  logic [DATA_W-1:0] msg_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rep_valid,
  output logic [PW-1:0]     rep_proc,
  output logic [ADDR_W-1:0] rep_addr,
  output logic [DATA_W-1:0] rep_data,
  output logic              rep_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [2:0]        dbg_state,
  output logic [N_PROC-1:0] dbg_sharers
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_MEMWB  = 3'd3;
  localparam logic [2:0] ST_MEMRD  = 3'd4;
  localparam logic [2:0] ST_REPLY  = 3'd5;

  localparam logic [2:0] DIR_I = 3'b001;
  localparam logic [2:0] DIR_S = 3'b010;
  localparam logic [2:0] DIR_M = 3'b011;

  localparam logic [1:0] T_RM = 2'b01;
  localparam logic [1:0] T_WM = 2'b10;
  localparam logic [1:0] T_WB = 2'b11;

  localparam logic [2:0] MSG_FETCH = 3'b011;
  localparam logic [2:0] MSG_FINV  = 3'b100;
  localparam logic [2:0] MSG_INV   = 3'b101;

  localparam int IW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam logic [ADDR_W:0] NB = (ADDR_W + 1)'(N_BLOCKS);

  // Block addresses are 1-based; 0 means "no block".
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} <= NB);
  endfunction

  function automatic logic [IW-1:0] toIdx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] t;
    t = a - 1'b1;
    return IW'(t);
  endfunction

  logic [2:0]        fsm;
  logic [1:0]        reqType;
  logic [PW-1:0]     reqProc;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic [DATA_W-1:0] replyData;
  logic              replyErr;
  logic [2:0]        msgTypeReg;
  logic [N_PROC-1:0] msgDestReg;
  logic [DATA_W-1:0] wbData;

  logic [2:0]        dirState   [N_BLOCKS];
  logic [N_PROC-1:0] dirSharers [N_BLOCKS];

  logic              addrOk;
  logic [IW-1:0]     idx;
  logic [2:0]        curState;
  logic [N_PROC-1:0] curSharers;
  logic [N_PROC-1:0] pMask;
  logic [N_PROC-1:0] others;
  logic              dbgOk;
  logic [IW-1:0]     dbgIdx;

  assign addrOk     = inRange(reqAddr);
  assign idx        = addrOk ? toIdx(reqAddr) : '0;
  assign curState   = dirState[idx];
  assign curSharers = dirSharers[idx];
  assign pMask      = N_PROC'(1) << reqProc;
  assign others     = curSharers & ~pMask;

  // Transaction sequencer: capture, classify, then walk message/memory handshakes to the reply.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fsm        <= ST_IDLE;
      reqType    <= '0;
      reqProc    <= '0;
      reqAddr    <= '0;
      reqData    <= '0;
      replyData  <= '0;
      replyErr   <= 1'b0;
      msgTypeReg <= '0;
      msgDestReg <= '0;
      wbData     <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (req_valid) begin
            reqType <= req_type;
            reqProc <= req_proc;
            reqAddr <= req_addr;
            reqData <= req_data;
            fsm     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          replyErr  <= 1'b0;
          replyData <= '0;
          if (!addrOk) begin
            replyErr <= 1'b1;
            fsm      <= ST_REPLY;
          end else begin
            case (reqType)
              T_RM: begin
                if (curState == DIR_M) begin
                  msgTypeReg <= MSG_FETCH;
                  msgDestReg <= curSharers;
                  fsm        <= ST_SEND;
                end else begin
                  fsm <= ST_MEMRD;
                end
              end
              T_WM: begin
                if (curState == DIR_M) begin
                  if (curSharers == pMask) begin
                    // Owner asking for ownership it already has is a protocol error.
                    replyErr <= 1'b1;
                    fsm      <= ST_REPLY;
                  end else begin
                    msgTypeReg <= MSG_FINV;
                    msgDestReg <= curSharers;
                    fsm        <= ST_SEND;
                  end
                end else if (curState == DIR_S && others != '0) begin
                  msgTypeReg <= MSG_INV;
                  msgDestReg <= others;
                  fsm        <= ST_SEND;
                end else begin
                  fsm <= ST_MEMRD;
                end
              end
              T_WB: begin
                if (curState == DIR_M && curSharers == pMask) begin
                  wbData    <= reqData;
                  replyData <= reqData;
                  fsm       <= ST_MEMWB;
                end else begin
                  replyErr <= 1'b1;
                  fsm      <= ST_REPLY;
                end
              end
              default: begin
                replyErr <= 1'b1;
                fsm      <= ST_REPLY;
              end
            endcase
          end
        end
        ST_SEND: begin
          if (msg_ack) begin
            if (msgTypeReg == MSG_INV) begin
              fsm <= ST_MEMRD;
            end else begin
              // Owner's dirty data goes both to memory and to the requester.
              wbData    <= msg_data;
              replyData <= msg_data;
              fsm       <= ST_MEMWB;
            end
          end
        end
        ST_MEMWB: begin
          if (mem_ack) fsm <= ST_REPLY;
        end
        ST_MEMRD: begin
          if (mem_ack) begin
            replyData <= mem_rdata;
            fsm       <= ST_REPLY;
          end
        end
        ST_REPLY: begin
          fsm <= ST_IDLE;
        end
        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

  // Directory entries change only in the reply cycle so an aborted transaction leaves no trace.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_BLOCKS; i++) begin
        dirState[i]   <= DIR_I;
        dirSharers[i] <= '0;
      end
    end else if (fsm == ST_REPLY && !replyErr) begin
      case (reqType)
        T_RM: begin
          dirState[idx]   <= DIR_S;
          dirSharers[idx] <= curSharers | pMask;
        end
        T_WM: begin
          dirState[idx]   <= DIR_M;
          dirSharers[idx] <= pMask;
        end
        T_WB: begin
          dirState[idx]   <= DIR_I;
          dirSharers[idx] <= '0;
        end
        default: begin
          dirState[idx]   <= dirState[idx];
          dirSharers[idx] <= dirSharers[idx];
        end
      endcase
    end
  end

  assign req_ready = (fsm == ST_IDLE) && !Reset;

  assign msg_valid = (fsm == ST_SEND);
  assign msg_type  = msg_valid ? msgTypeReg : '0;
  assign msg_dest  = msg_valid ? msgDestReg : '0;
  assign msg_addr  = msg_valid ? reqAddr : '0;

  assign mem_rd    = (fsm == ST_MEMRD);
  assign mem_wr    = (fsm == ST_MEMWB);
  assign mem_addr  = (mem_rd || mem_wr) ? reqAddr : '0;
  assign mem_wdata = mem_wr ? wbData : '0;

  assign rep_valid = (fsm == ST_REPLY);
  assign rep_proc  = rep_valid ? reqProc : '0;
  assign rep_addr  = rep_valid ? reqAddr : '0;
  assign rep_data  = rep_valid ? replyData : '0;
  assign rep_err   = rep_valid & replyErr;

  assign dbgOk       = inRange(dbg_addr);
  assign dbgIdx      = dbgOk ? toIdx(dbg_addr) : '0;
  assign dbg_state   = dbgOk ? dirState[dbgIdx] : 3'b000;
  assign dbg_sharers = dbgOk ? dirSharers[dbgIdx] : '0;

endmodule

// File: tb/tb_diretorio_msi_n.sv
// tb/tb_diretorio_msi_n.sv - directed self-checking bench for diretorio_msi_n
module tb_diretorio_msi_n;

  localparam int NP = 2;
  localparam int PW = 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_type;
  logic [PW-1:0] req_proc;
  logic [3:0]    req_addr;
  logic [3:0]    req_data;
  logic          msg_valid;
  logic [2:0]    msg_type;
  logic [NP-1:0] msg_dest;
  logic [3:0]    msg_addr;
  logic          msg_ack;
  logic [3:0]    msg_data;
  logic          mem_rd;
  logic          mem_wr;
  logic [3:0]    mem_addr;
  logic [3:0]    mem_wdata;
  logic [3:0]    mem_rdata;
  logic          mem_ack;
  logic          rep_valid;
  logic [PW-1:0] rep_proc;
  logic [3:0]    rep_addr;
  logic [3:0]    rep_data;
  logic          rep_err;
  logic [3:0]    dbg_addr;
  logic [2:0]    dbg_state;
  logic [NP-1:0] dbg_sharers;

  diretorio_msi_n dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_proc(req_proc), .req_addr(req_addr), .req_data(req_data),
    .msg_valid(msg_valid), .msg_type(msg_type), .msg_dest(msg_dest),
    .msg_addr(msg_addr), .msg_ack(msg_ack), .msg_data(msg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rep_valid(rep_valid), .rep_proc(rep_proc), .rep_addr(rep_addr),
    .rep_data(rep_data), .rep_err(rep_err),
    .dbg_addr(dbg_addr), .dbg_state(dbg_state), .dbg_sharers(dbg_sharers)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         repK;
  logic [3:0] rData;
  logic [3:0] rAddr;
  logic [PW-1:0] rProc;
  logic       rErr;
  logic       sawMsg;
  logic [2:0] mType;
  logic [NP-1:0] mDest;
  logic [3:0] mAddr;
  logic       msgUnstable;
  int         msgCycles;
  logic       sawRd;
  logic       sawWr;
  logic [3:0] memA;
  logic [3:0] memW;

  task automatic doReq(input logic [1:0] t, input logic [PW-1:0] p, input logic [3:0] a,
                       input logic [3:0] d, input int ackDly, input logic [3:0] mData,
                       input logic [3:0] rdData, input bit noise);
    repK = -1; rData = '0; rAddr = '0; rProc = '0; rErr = 1'b0;
    sawMsg = 1'b0; mType = '0; mDest = '0; mAddr = '0; msgUnstable = 1'b0; msgCycles = 0;
    sawRd = 1'b0; sawWr = 1'b0; memA = '0; memW = '0;
    @(negedge Clock);
    checkVal("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_type = t; req_proc = p; req_addr = a; req_data = d;
    @(negedge Clock);
    if (noise) begin
      req_type = 2'b10; req_proc = '0; req_addr = 4'd2; req_data = 4'hf;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 1; k <= 40; k++) begin
      if (msg_valid) begin
        if (!sawMsg) begin
          sawMsg = 1'b1; mType = msg_type; mDest = msg_dest; mAddr = msg_addr;
        end else if (msg_type !== mType || msg_dest !== mDest || msg_addr !== mAddr) begin
          msgUnstable = 1'b1;
        end
        msgCycles++;
      end
      if (mem_rd) begin sawRd = 1'b1; memA = mem_addr; end
      if (mem_wr) begin sawWr = 1'b1; memA = mem_addr; memW = mem_wdata; end
      mem_ack   = mem_rd | mem_wr;
      mem_rdata = mem_rd ? rdData : 4'h0;
      msg_ack   = msg_valid && (msgCycles > ackDly);
      msg_data  = msg_ack ? mData : 4'h0;
      if (rep_valid) begin
        repK = k; rData = rep_data; rAddr = rep_addr; rProc = rep_proc; rErr = rep_err;
        break;
      end
      @(negedge Clock);
    end
    req_valid = 1'b0; mem_ack = 1'b0; msg_ack = 1'b0; msg_data = '0; mem_rdata = '0;
    @(negedge Clock);
    checkVal("rep_one_cycle", {31'd0, rep_valid}, 32'd0);
  endtask

  task automatic dbgChk(input logic [3:0] a, input logic [2:0] st, input logic [NP-1:0] sh);
    dbg_addr = a;
    #1;
    checkVal($sformatf("dbg_state_a%0d", a), {29'd0, dbg_state}, {29'd0, st});
    checkVal($sformatf("dbg_sharers_a%0d", a), {30'd0, dbg_sharers}, {30'd0, sh});
  endtask

  logic repSeen;

  initial begin
    Reset = 1'b1; req_valid = 1'b0; req_type = '0; req_proc = '0; req_addr = '0; req_data = '0;
    msg_ack = 1'b0; msg_data = '0; mem_rdata = '0; mem_ack = 1'b0; dbg_addr = '0;
    @(negedge Clock);
    checkVal("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkVal("rst_rep_valid", {31'd0, rep_valid}, 32'd0);
    checkVal("rst_msg_valid", {31'd0, msg_valid}, 32'd0);
    checkVal("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    checkVal("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    dbgChk(4'd1, 3'b001, 2'b00);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checkVal("release_req_ready", {31'd0, req_ready}, 32'd1);

    // ReadMiss P0 on I, with a concurrent request held high that must be ignored
    doReq(2'b01, 1'b0, 4'd1, 4'd0, 0, 4'd0, 4'd1, 1'b1);
    checkVal("rm1_latency", repK, 32'd3);
    checkVal("rm1_data", {28'd0, rData}, 32'd1);
    checkVal("rm1_proc", {31'd0, rProc}, 32'd0);
    checkVal("rm1_addr", {28'd0, rAddr}, 32'd1);
    checkVal("rm1_err", {31'd0, rErr}, 32'd0);
    checkVal("rm1_memrd", {31'd0, sawRd}, 32'd1);
    checkVal("rm1_memaddr", {28'd0, memA}, 32'd1);
    checkVal("rm1_nomsg", {31'd0, sawMsg}, 32'd0);
    dbgChk(4'd1, 3'b010, 2'b01);
    dbgChk(4'd2, 3'b001, 2'b00);

    // ReadMiss P1 on S
    doReq(2'b01, 1'b1, 4'd1, 4'd0, 0, 4'd0, 4'd2, 1'b0);
    checkVal("rm2_latency", repK, 32'd3);
    checkVal("rm2_data", {28'd0, rData}, 32'd2);
    checkVal("rm2_proc", {31'd0, rProc}, 32'd1);
    dbgChk(4'd1, 3'b010, 2'b11);

    // WriteMiss P0 on S: Invalidate to P1 held two extra cycles
    doReq(2'b10, 1'b0, 4'd1, 4'd0, 2, 4'd0, 4'd3, 1'b0);
    checkVal("wm_msg_type", {29'd0, mType}, 32'b101);
    checkVal("wm_msg_dest", {30'd0, mDest}, 32'b10);
    checkVal("wm_msg_addr", {28'd0, mAddr}, 32'd1);
    checkVal("wm_msg_stable", {31'd0, msgUnstable}, 32'd0);
    checkVal("wm_msg_cycles", msgCycles, 32'd3);
    checkVal("wm_memrd", {31'd0, sawRd}, 32'd1);
    checkVal("wm_latency", repK, 32'd6);
    checkVal("wm_data", {28'd0, rData}, 32'd3);
    dbgChk(4'd1, 3'b011, 2'b01);

    // ReadMiss P1 on M owned by P0: Fetch and write back owner data
    doReq(2'b01, 1'b1, 4'd1, 4'd0, 0, 4'd5, 4'd0, 1'b0);
    checkVal("fetch_msg_type", {29'd0, mType}, 32'b011);
    checkVal("fetch_msg_dest", {30'd0, mDest}, 32'b01);
    checkVal("fetch_memwr", {31'd0, sawWr}, 32'd1);
    checkVal("fetch_memaddr", {28'd0, memA}, 32'd1);
    checkVal("fetch_memwdata", {28'd0, memW}, 32'd5);
    checkVal("fetch_nomemrd", {31'd0, sawRd}, 32'd0);
    checkVal("fetch_data", {28'd0, rData}, 32'd5);
    checkVal("fetch_proc", {31'd0, rProc}, 32'd1);
    checkVal("fetch_latency", repK, 32'd4);
    dbgChk(4'd1, 3'b010, 2'b11);

    // WriteBack on S state is an error
    doReq(2'b11, 1'b0, 4'd1, 4'd9, 0, 4'd0, 4'd0, 1'b0);
    checkVal("wb_s_err", {31'd0, rErr}, 32'd1);
    dbgChk(4'd1, 3'b010, 2'b11);

    // WriteMiss P1 on I of block 2, then protocol errors and a legal WriteBack
    doReq(2'b10, 1'b1, 4'd2, 4'd0, 0, 4'd0, 4'd7, 1'b0);
    checkVal("wm_i_data", {28'd0, rData}, 32'd7);
    checkVal("wm_i_nomsg", {31'd0, sawMsg}, 32'd0);
    dbgChk(4'd2, 3'b011, 2'b10);
    doReq(2'b10, 1'b1, 4'd2, 4'd0, 0, 4'd0, 4'd0, 1'b0);
    checkVal("wm_owner_err", {31'd0, rErr}, 32'd1);
    dbgChk(4'd2, 3'b011, 2'b10);
    doReq(2'b11, 1'b0, 4'd2, 4'd8, 0, 4'd0, 4'd0, 1'b0);
    checkVal("wb_nonowner_err", {31'd0, rErr}, 32'd1);
    checkVal("wb_nonowner_nomem", {31'd0, sawWr}, 32'd0);
    dbgChk(4'd2, 3'b011, 2'b10);
    doReq(2'b11, 1'b1, 4'd2, 4'd9, 0, 4'd0, 4'd0, 1'b0);
    checkVal("wb_err", {31'd0, rErr}, 32'd0);
    checkVal("wb_memwdata", {28'd0, memW}, 32'd9);
    checkVal("wb_data", {28'd0, rData}, 32'd9);
    dbgChk(4'd2, 3'b001, 2'b00);

    // Illegal addresses
    doReq(2'b01, 1'b0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1'b0);
    checkVal("addr0_err", {31'd0, rErr}, 32'd1);
    checkVal("addr0_latency", repK, 32'd2);
    doReq(2'b10, 1'b1, 4'd9, 4'd0, 0, 4'd0, 4'd0, 1'b0);
    checkVal("addr9_err", {31'd0, rErr}, 32'd1);
    dbgChk(4'd0, 3'b000, 2'b00);
    dbgChk(4'd9, 3'b000, 2'b00);
    dbgChk(4'd8, 3'b001, 2'b00);
    dbgChk(4'd1, 3'b010, 2'b11);

    // Reset while an Invalidate waits for its acknowledge
    @(negedge Clock);
    req_valid = 1'b1; req_type = 2'b10; req_proc = 1'b1; req_addr = 4'd1; req_data = 4'd0;
    @(negedge Clock);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !msg_valid; k++) @(negedge Clock);
    checkVal("abort_msg_pending", {31'd0, msg_valid}, 32'd1);
    checkVal("abort_msg_dest", {30'd0, msg_dest}, 32'b01);
    #2;
    Reset = 1'b1;
    #1;
    checkVal("abort_msg_valid", {31'd0, msg_valid}, 32'd0);
    checkVal("abort_msg_type", {29'd0, msg_type}, 32'd0);
    checkVal("abort_msg_dest0", {30'd0, msg_dest}, 32'd0);
    checkVal("abort_msg_addr", {28'd0, msg_addr}, 32'd0);
    checkVal("abort_req_ready", {31'd0, req_ready}, 32'd0);
    checkVal("abort_rep_valid", {31'd0, rep_valid}, 32'd0);
    repSeen = 1'b0;
    @(negedge Clock);
    repSeen = repSeen | rep_valid;
    Reset = 1'b0;
    #1;
    checkVal("abort_release_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      repSeen = repSeen | rep_valid;
    end
    checkVal("abort_no_reply", {31'd0, repSeen}, 32'd0);
    for (int a = 1; a <= 8; a++) dbgChk(4'(a), 3'b001, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/diretorio_msi_n.md
DIRETORIO_MSI_N -- requirements
Module: diretorio_msi_n

Interface
REQ-001 SHALL have parameters: N_PROC, default 2, number of processors; N_BLOCKS, default 8, tracked blocks; ADDR_W, default 4, address width; DATA_W, default 4, data width; PW = max(1, clog2(N_PROC)).
REQ-002 SHALL have ports (name  direction  width  meaning):
 Clock  in  1  single clock, rising edge.
 Reset  in  1  asynchronous, active-high reset.
 req_valid  in  1  request present.
 req_ready  out  1  request accepted when high with req_valid.
 req_type  in  2  01 ReadMiss, 10 WriteMiss, 11 WriteBack.
 req_proc  in  PW  requesting processor.
 req_addr  in  ADDR_W  block address; 1..N_BLOCKS legal, 0 = empty.
 req_data  in  DATA_W  WriteBack data.
 msg_valid  out  1  coherence message pending.
 msg_type  out  3  011 Fetch, 100 FetchInvalidate, 101 Invalidate.
 msg_dest  out  N_PROC  one-hot/multicast destination mask.
 msg_addr  out  ADDR_W  message block address.
 msg_ack  in  1  aggregated acknowledge from all destinations.
 msg_data  in  DATA_W  owner data, valid with msg_ack on Fetch/FetchInvalidate.
 mem_rd, mem_wr  out  1 each  memory read/write request.
 mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W.
 mem_rdata  in  DATA_W  valid with mem_ack;  mem_ack  in  1.
 rep_valid  out  1  one-cycle reply pulse.
 rep_proc  out  PW;  rep_addr  out  ADDR_W;  rep_data  out  DATA_W;  rep_err  out  1.
 dbg_addr  in  ADDR_W;  dbg_state  out  3;  dbg_sharers  out  N_PROC  combinational directory query.

Function
REQ-003 SHALL hold per block: state (001 I, 010 S, 011 M) and an N_PROC-bit sharer vector; index = req_addr - 1.
REQ-004 SHALL implement FSM IDLE, LOOKUP, SEND_MSG, MEM_WB, MEM_RD, REPLY; req_ready = 1 only in IDLE.
REQ-005 IDLE: on req_valid capture type/proc/addr/data, go to LOOKUP next cycle.
REQ-006 LOOKUP: addr 0 or > N_BLOCKS -> REPLY with rep_err = 1, no state change.
REQ-007 ReadMiss, state I or S -> MEM_RD -> REPLY; final state S, sharers |= {P}.
REQ-008 ReadMiss, state M, owner O -> SEND_MSG Fetch to {O} -> MEM_WB(msg_data) -> REPLY(msg_data); final S, sharers = {O,P}.
REQ-009 WriteMiss, state I -> MEM_RD -> REPLY; final M, {P}.
REQ-010 WriteMiss, state S -> Invalidate to sharers & ~{P} (skip SEND_MSG if empty) -> MEM_RD -> REPLY; final M, {P}.
REQ-011 WriteMiss, state M, O != P -> FetchInvalidate to {O} -> MEM_WB(msg_data) -> REPLY(msg_data); final M, {P}; O == P -> REPLY rep_err = 1, no change.
REQ-012 WriteBack, state M and P == owner -> MEM_WB(req_data) -> REPLY(rep_data = req_data); final I, sharers 0; otherwise REPLY rep_err = 1, no change.
REQ-013 msg_valid, mem_rd and mem_wr SHALL stay high with stable address/data until the ack is sampled high; the request drops the cycle after the ack.
REQ-014 Directory update SHALL occur in the REPLY cycle; rep_valid high for exactly that one cycle; no backpressure on replies.
REQ-015 Latency, ReadMiss on I with mem_ack in the first MEM_RD cycle: accept in cycle 0, rep_valid in cycle 3.
REQ-016 req_valid while not IDLE SHALL be ignored (not captured).
REQ-017 dbg_addr 0 or out of range SHALL return dbg_state 000, dbg_sharers 0.

Reset
REQ-018 Reset high SHALL immediately force: FSM IDLE, all entries I with sharers 0, all outputs 0 except req_ready.
REQ-019 req_ready SHALL be 0 while Reset is high and 1 in the first cycle after release.
REQ-020 Reset mid-transaction SHALL abort it with no reply and no directory update.

Verification (N_PROC = 2)
REQ-021 Reset; ReadMiss P0 addr 0001, mem_ack immediate, mem_rdata 0001 -> rep_valid cycle 3, rep_data 0001, rep_proc 0; entry S, sharers 01.
REQ-022 Then ReadMiss P1 addr 0001 -> memory read, reply; entry S, sharers 11.
REQ-023 Then WriteMiss P0 addr 0001 -> msg Invalidate, dest 10, held until msg_ack; then mem_rd, reply; entry M, sharers 01.
REQ-024 Then ReadMiss P1 addr 0001 -> Fetch dest 01; msg_data 0101 -> mem_wr addr 0001 data 0101, reply 0101 to P1; entry S, sharers 11.
REQ-025 WriteBack from a non-owner, and any request with addr 0000 -> rep_err 1, entry unchanged.
REQ-026 Reset asserted while msg_valid waits for msg_ack -> all outputs 0 in the same cycle, no rep_valid, every entry reads 001/00.
